// File: rtl/bcd_pkg.sv
// Shared constants for the BCD modulo-N counter: widths, seven-segment patterns
// (a..g MSB to LSB, active-high) and a constant-time integer-to-BCD helper.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Used only on parameters (MOD-1) to build terminal constants at elaboration.
    function automatic logic [4*BCD_W-1:0] to_bcd(input int unsigned v);
        int unsigned r;
        logic [4*BCD_W-1:0] b;
        r = v;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[BCD_W*i +: BCD_W] = BCD_W'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One-digit BCD to seven-segment decoder; non-decimal codes blank the digit.
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_modn_counter.sv
// Multi-digit BCD modulo-MOD counter with load, cascadable tc and per-digit
// seven-segment drive. Define BCD_CNT_UPDOWN_EN to add the dn port and down counting.
module bcd_modn_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MOD    = 60
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
`ifdef BCD_CNT_UPDOWN_EN
    input  logic                      dn,
`endif
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic [SEG_W*DIGITS-1:0]   seg,
    output logic                      tc
);

    localparam int CW = BCD_W * DIGITS;
    localparam logic [CW-1:0] TERM_UP = CW'(to_bcd(MOD - 1));

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inc_v;
    logic          load_ok;
    logic          at_term;
    logic          carry;

    // Valid BCD compares in the same order as its decimal value, so the
    // range check is a plain vector compare against MOD-1.
    always_comb begin
        load_ok = (load_val <= TERM_UP);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[BCD_W*i +: BCD_W] > 4'd9) load_ok = 1'b0;
        end
    end

    always_comb begin
        inc_v = count_q;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[BCD_W*i +: BCD_W] == 4'd9) begin
                    inc_v[BCD_W*i +: BCD_W] = 4'd0;
                end else begin
                    inc_v[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

`ifdef BCD_CNT_UPDOWN_EN
    logic [CW-1:0] dec_v;
    logic          borrow;

    always_comb begin
        dec_v  = count_q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[BCD_W*i +: BCD_W] == 4'd0) begin
                    dec_v[BCD_W*i +: BCD_W] = 4'd9;
                end else begin
                    dec_v[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign at_term = dn ? (count_q == '0) : (count_q == TERM_UP);

    always_comb begin
        count_d = count_q;
        if (load)         count_d = load_ok ? load_val : '0;
        else if (en) begin
            if (at_term)  count_d = dn ? TERM_UP : '0;
            else          count_d = dn ? dec_v : inc_v;
        end
    end
`else
    assign at_term = (count_q == TERM_UP);

    always_comb begin
        count_d = count_q;
        if (load)         count_d = load_ok ? load_val : '0;
        else if (en)      count_d = at_term ? '0 : inc_v;
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;
    assign tc    = clr & en & ~load & at_term;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .bcd_i (count_q[BCD_W*g +: BCD_W]),
            .seg_o (seg[SEG_W*g +: SEG_W])
        );
    end

endmodule
